// File: rtl/rand_delay_timer.sv
// Reaction-tester timer: random pre-stimulus delay, then reaction time measured in ms.
// Optional REACT_BEST_EN adds a best_ms output holding the fastest valid reaction since reset.
//   state | meaning
//   IDLE  | waiting for start, last result held
//   DELAY | counting down the random delay, button press is a false start
//   REACT | stimulus lit, counting ms up to the button press or timeout
module rand_delay_timer #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int MAX_REACT_MS = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  rand_num,
    input  logic        btn,
    output logic        stim,
    output logic        busy,
    output logic [13:0] result_ms,
    output logic        result_valid,
    output logic        false_start,
`ifdef REACT_BEST_EN
    output logic        timeout,
    output logic [13:0] best_ms
`else
    output logic        timeout
`endif
);

    localparam int TICK = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
    localparam int PW   = (TICK > 1) ? $clog2(TICK) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK - 1);
    localparam logic [13:0]   MAX_MS   = 14'(MAX_REACT_MS);
    localparam logic [13:0]   MIN_MS   = 14'(MIN_DELAY_MS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DELAY = 2'd1;
    localparam logic [1:0] S_REACT = 2'd2;

    logic [1:0]    state;
    logic [PW-1:0] pre;
    logic [13:0]   cnt;
    logic          tick;

    assign tick = (pre == PRE_LAST);
    assign stim = (state == S_REACT);
    assign busy = (state == S_DELAY) || (state == S_REACT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            pre          <= '0;
            cnt          <= '0;
            result_ms    <= '0;
            result_valid <= 1'b0;
            false_start  <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            // free-running inside a state; every transition below forces it back to 0
            pre <= (state == S_IDLE || tick) ? '0 : pre + 1'b1;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_DELAY;
                        pre         <= '0;
                        cnt         <= MIN_MS + {4'b0, rand_num};
                        result_ms   <= '0;
                        false_start <= 1'b0;
                        timeout     <= 1'b0;
                    end
                end
                S_DELAY: begin
                    if (btn) begin
                        state        <= S_IDLE;
                        pre          <= '0;
                        false_start  <= 1'b1;
                        result_ms    <= '0;
                        result_valid <= 1'b1;
                    end else if (tick) begin
                        if (cnt <= 14'd1) begin
                            state <= S_REACT;
                            pre   <= '0;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt - 14'd1;
                        end
                    end
                end
                S_REACT: begin
                    if (btn) begin
                        state        <= S_IDLE;
                        pre          <= '0;
                        result_ms    <= cnt;
                        result_valid <= 1'b1;
                    end else if (cnt == MAX_MS) begin
                        state        <= S_IDLE;
                        pre          <= '0;
                        timeout      <= 1'b1;
                        result_ms    <= MAX_MS;
                        result_valid <= 1'b1;
                    end else if (tick) begin
                        cnt <= cnt + 14'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    pre   <= '0;
                end
            endcase
        end
    end

`ifdef REACT_BEST_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            best_ms <= 14'h3FFF;
        end else if (result_valid && !false_start && !timeout && (result_ms < best_ms)) begin
            best_ms <= result_ms;
        end
    end
`endif

endmodule

// File: tb/tb_rand_delay_timer.sv
// Bench for rand_delay_timer with TICK=1, MIN_DELAY_MS=5, MAX_REACT_MS=20.
// Expected timing is derived per trial from the delay/press arithmetic, not from the FSM.
module tb_rand_delay_timer;

    localparam int MIN = 5;
    localparam int MAX = 20;

    logic        clk = 1'b0;
    logic        rst, start, btn;
    logic [9:0]  rand_num;
    logic        stim, busy, result_valid, false_start, timeout;
    logic [13:0] result_ms;
`ifdef REACT_BEST_EN
    logic [13:0] best_ms;
    int          best_exp = 16'h3FFF;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rand_delay_timer #(
        .CLK_HZ(1000),
        .MIN_DELAY_MS(MIN),
        .MAX_REACT_MS(MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .rand_num(rand_num),
        .btn(btn),
        .stim(stim),
        .busy(busy),
        .result_ms(result_ms),
        .result_valid(result_valid),
        .false_start(false_start),
`ifdef REACT_BEST_EN
        .timeout(timeout),
        .best_ms(best_ms)
`else
        .timeout(timeout)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge with the DUT idle. Cycle k=0 is the first DELAY cycle;
    // btn is held from cycle btn_at until the trial ends.
    task automatic run_trial(input int r, input int btn_at, input bit btn_with_start);
        int d, fin, res;
        bit fs = 1'b0;
        bit to = 1'b0;
        d = MIN + r;
        if (btn_with_start) btn_at = 0;
        if (btn_at < d) begin
            fs = 1'b1; res = 0; fin = btn_at + 1;
        end else if (btn_at <= d + MAX) begin
            res = btn_at - d; fin = btn_at + 1;
        end else begin
            to = 1'b1; res = MAX; fin = d + MAX + 1;
        end
`ifdef REACT_BEST_EN
        if (!fs && !to && res < best_exp) best_exp = res;
`endif
        rand_num = 10'(r);
        start    = 1'b1;
        btn      = btn_with_start;
        @(posedge clk); #1;
        for (int k = 0; k <= fin + 2; k++) begin
            rand_num = 10'($urandom);
            btn      = (k >= btn_at) && (k < fin);
            start    = (k < fin) && ($urandom_range(0, 3) == 0);
            @(negedge clk);
            check("stim",         32'(stim),         32'((k >= d) && (k < fin)));
            check("busy",         32'(busy),         32'(k < fin));
            check("result_valid", 32'(result_valid), 32'(k == fin));
            if (k == fin) begin
                check("result_ms",   32'(result_ms),   32'(res));
                check("false_start", 32'(false_start), 32'(fs));
                check("timeout",     32'(timeout),     32'(to));
            end
            if (k == fin + 2) begin
                check("result_held", 32'(result_ms), 32'(res));
`ifdef REACT_BEST_EN
                check("best_ms", 32'(best_ms), 32'(best_exp));
`endif
            end
            @(posedge clk); #1;
        end
        btn   = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        int r;
        rst = 1'b1; start = 1'b0; btn = 1'b0; rand_num = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_stim",   32'(stim),         32'd0);
        check("rst_busy",   32'(busy),         32'd0);
        check("rst_result", 32'(result_ms),    32'd0);
        check("rst_valid",  32'(result_valid), 32'd0);
        check("rst_fs",     32'(false_start),  32'd0);
        check("rst_to",     32'(timeout),      32'd0);
`ifdef REACT_BEST_EN
        check("rst_best", 32'(best_ms), 32'h3FFF);
`endif
        @(posedge clk); #1;

        run_trial(3, MIN + 3 + 7, 1'b0);
        r = $urandom_range(0, 30);
        run_trial(r, MIN + r + 4, 1'b0);
        run_trial($urandom_range(0, 30), 2, 1'b0);
        r = $urandom_range(0, 30);
        run_trial(r, MIN + r + 9, 1'b0);
        run_trial(1, 100000, 1'b0);
        run_trial(0, MIN + 3, 1'b0);
        run_trial(1023, MIN + 1023 + MAX, 1'b0);
        r = $urandom_range(0, 30);
        run_trial(r, MIN + r - 1, 1'b0);
        run_trial($urandom_range(0, 30), 0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            r = $urandom_range(0, 40);
            run_trial(r, $urandom_range(0, MIN + r + MAX + 3), 1'b0);
        end

        rand_num = 10'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (MIN + 2 + 3) @(posedge clk);
        @(negedge clk);
        check("pre_rst_stim", 32'(stim), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_stim",   32'(stim),         32'd0);
        check("mid_rst_busy",   32'(busy),         32'd0);
        check("mid_rst_result", 32'(result_ms),    32'd0);
        check("mid_rst_valid",  32'(result_valid), 32'd0);
`ifdef REACT_BEST_EN
        best_exp = 16'h3FFF;
        check("mid_rst_best", 32'(best_ms), 32'h3FFF);
`endif
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_valid", 32'(result_valid), 32'd0);
        end
        @(posedge clk); #1;
        run_trial(4, MIN + 4 + 6, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
